// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
// Shared definitions between the selector mux and its downstream consumers.
//   - Selector encodings for the four legal mux inputs (B, E, A, D).
//   - SEL_MAX: the highest legal selector value. Anything above it makes
//     the mux drive its default nibble Q_DEFAULT.
//   - nibble_t: the 4-bit data type produced by the mux.
//   - sel_out_of_range(): flags a selector value that is out of range.
// ---------------------------------------------------------------------------
package mux_pkg;

    typedef logic [3:0] nibble_t;

    localparam nibble_t SEL_B     = 4'd0;
    localparam nibble_t SEL_E     = 4'd1;
    localparam nibble_t SEL_A     = 4'd2;
    localparam nibble_t SEL_D     = 4'd3;
    localparam nibble_t SEL_MAX   = 4'd3;
    localparam nibble_t Q_DEFAULT = 4'hf;

    // True when the selector did not address any real mux input.
    function automatic logic sel_out_of_range(input nibble_t sel);
        return (sel > SEL_MAX);
    endfunction

endpackage : mux_pkg

// File: rtl/nibble_accumulator.sv
// ---------------------------------------------------------------------------
// nibble_accumulator
// Holds the partially built word and detects when it must close.
//   clk, reset   : clock, synchronous active-high reset
//   accept       : a nibble is transferred this cycle
//   in_q         : nibble data, packed unmodified
//   in_sel       : selector that produced in_q (error source)
//   in_last      : close the word after this nibble
//   close        : this accept completes the word
//   word_data    : accumulator merged with the incoming nibble; upper nibbles 0
//   word_len     : nibble count of the word if it closes now (idx+1)
//   word_err     : sticky word error merged with the incoming nibble's flag
//   nib_err      : incoming nibble's selector is out of range
// ---------------------------------------------------------------------------
module nibble_accumulator
    import mux_pkg::*;
#(
    parameter int NIBBLES = 4,
    parameter int LENW    = $clog2(NIBBLES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   accept,
    input  nibble_t                in_q,
    input  nibble_t                in_sel,
    input  logic                   in_last,
    output logic                   close,
    output logic [4*NIBBLES-1:0]   word_data,
    output logic [LENW-1:0]        word_len,
    output logic                   word_err,
    output logic                   nib_err
);

    localparam logic [LENW-1:0] LAST_IDX = LENW'(NIBBLES - 1);

    logic [4*NIBBLES-1:0] acc_q, acc_d;
    logic [LENW-1:0]      idx_q, idx_d;
    logic                 werr_q, werr_d;

    // Merge the incoming nibble into the accumulator and detect word close.
    always_comb begin
        nib_err   = sel_out_of_range(in_sel);
        close     = accept && ((idx_q == LAST_IDX) || in_last);
        word_len  = idx_q + LENW'(1);
        word_err  = werr_q | nib_err;
        word_data = acc_q;
        // Slots above idx are still zero because a close clears acc.
        for (int k = 0; k < NIBBLES; k++) begin
            if (idx_q == LENW'(k)) begin
                word_data[4*k +: 4] = in_q;
            end else begin
                word_data[4*k +: 4] = acc_q[4*k +: 4];
            end
        end
    end

    // Next-state of the accumulator: only accepts change it.
    always_comb begin
        acc_d  = acc_q;
        idx_d  = idx_q;
        werr_d = werr_q;
        if (!accept) begin
            acc_d  = acc_q;
            idx_d  = idx_q;
            werr_d = werr_q;
        end else if (close) begin
            acc_d  = '0;
            idx_d  = '0;
            werr_d = 1'b0;
        end else begin
            acc_d  = word_data;
            idx_d  = idx_q + LENW'(1);
            werr_d = word_err;
        end
    end

    // Accumulator state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            idx_q  <= '0;
            werr_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            idx_q  <= idx_d;
            werr_q <= werr_d;
        end
    end

endmodule : nibble_accumulator

// File: rtl/nibble_packer.sv
// ---------------------------------------------------------------------------
// nibble_packer
// Packs consecutive mux nibbles into a registered word with valid/ready.
//   clk, reset  : clock, synchronous active-high reset
//   in_valid    : nibble present          in_ready : packer can accept
//   in_q        : nibble data             in_sel   : selector behind in_q
//   in_last     : close word after this nibble
//   out_valid   : word register full      out_ready: consumer takes the word
//   out_data    : packed word, nibble k at [4k+3:4k], unfilled nibbles 0
//   out_len     : valid nibbles in out_data (1..NIBBLES)
//   out_err     : some nibble of the word had an out-of-range selector
//   err_count   : saturating count of accepted out-of-range nibbles
// in_ready is the only combinational input-to-output path (from out_ready).
// ---------------------------------------------------------------------------
module nibble_packer
    import mux_pkg::*;
#(
    parameter int NIBBLES = 4,
    parameter int LENW    = $clog2(NIBBLES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  nibble_t              in_q,
    input  nibble_t              in_sel,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] out_data,
    output logic [LENW-1:0]      out_len,
    output logic                 out_err,
    output logic [7:0]           err_count
);

    logic                 accept_s;
    logic                 close_s;
    logic [4*NIBBLES-1:0] word_data_s;
    logic [LENW-1:0]      word_len_s;
    logic                 word_err_s;
    logic                 nib_err_s;

    logic                 out_valid_q, out_valid_d;
    logic [4*NIBBLES-1:0] out_data_q,  out_data_d;
    logic [LENW-1:0]      out_len_q,   out_len_d;
    logic                 out_err_q,   out_err_d;
    logic [7:0]           err_count_q, err_count_d;

    // Handshake: room exists when the word register is empty or draining.
    always_comb begin
        in_ready = !out_valid_q || out_ready;
        accept_s = in_valid && in_ready;
    end

    nibble_accumulator #(
        .NIBBLES (NIBBLES),
        .LENW    (LENW)
    ) u_acc (
        .clk       (clk),
        .reset     (reset),
        .accept    (accept_s),
        .in_q      (in_q),
        .in_sel    (in_sel),
        .in_last   (in_last),
        .close     (close_s),
        .word_data (word_data_s),
        .word_len  (word_len_s),
        .word_err  (word_err_s),
        .nib_err   (nib_err_s)
    );

    // Output register next-state: a close reloads even while draining,
    // which is what keeps back-to-back words bubble-free.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_len_d   = out_len_q;
        out_err_d   = out_err_q;
        if (close_s) begin
            out_valid_d = 1'b1;
            out_data_d  = word_data_s;
            out_len_d   = word_len_s;
            out_err_d   = word_err_s;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Saturating error counter next-state.
    always_comb begin
        err_count_d = err_count_q;
        if (accept_s && nib_err_s && (err_count_q != 8'hff)) begin
            err_count_d = err_count_q + 8'd1;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Output and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_len_q   <= '0;
            out_err_q   <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_len_q   <= out_len_d;
            out_err_q   <= out_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_len   = out_len_q;
    assign out_err   = out_err_q;
    assign err_count = err_count_q;

endmodule : nibble_packer

// File: doc/nibble_packer.md
# nibble_packer

Downstream stage of the selector mux: consumes its 4-bit `q` output one nibble per handshake and packs consecutive nibbles into a wide word. It also takes the selector value that produced each nibble and flags out-of-range selections, where `q` is the default 4'hf. The output is a registered word with valid/ready handshake, feeding the capture/scoreboard logic.

## Interface
- `NIBBLES`, default 4: nibbles per output word; legal range 2..8.
- `LENW`, default $clog2(NIBBLES+1): width of `out_len`; derived, not overridden.
- `clk  in  1`: single clock; all state updates on rising edge.
- `reset  in  1`: synchronous reset, active-high.
- `in_valid  in  1`: nibble present.
- `in_ready  out  1`: packer can accept; equals `!out_valid || out_ready` (combinational).
- `in_q  in  4`: mux output nibble.
- `in_sel  in  4`: selector value that produced `in_q`.
- `in_last  in  1`: close the current word after this nibble.
- `out_valid  out  1`: word register holds a word.
- `out_ready  in  1`: consumer accepts the word.
- `out_data  out  4*NIBBLES`: packed word; nibble k at bits [4k+3:4k]; unfilled nibbles are 0.
- `out_len  out  LENW`: number of valid nibbles in `out_data`, 1..NIBBLES.
- `out_err  out  1`: at least one nibble in the word had `in_sel` > 3.
- `err_count  out  8`: saturating count of accepted out-of-range nibbles.

## Operation
- Accept occurs when `in_valid && in_ready`. Only accepts change the accumulator `acc`, the index `idx`, the word-error flag `werr`, or `err_count`.
- On accept:
  - `acc[4*idx +: 4] <= in_q`.
  - `werr` is ORed with (`in_sel` > SEL_MAX).
  - `err_count` increments when `in_sel` > SEL_MAX and holds at 255.
- Close condition: accept with `idx == NIBBLES-1` or `in_last == 1`.
- On close, the output register loads in the same edge:
  - `out_data` = `acc` merged with the new nibble, higher nibbles zero.
  - `out_len` = `idx+1`.
  - `out_err` = `werr` ORed with the new nibble's flag.
  - `out_valid` <= 1.
  - `acc`, `idx` and `werr` clear to 0.
- Non-closing accept: `idx <= idx+1`.
- Drain: `out_valid && out_ready` with no simultaneous close drives `out_valid` to 0.
  - Drain and close in the same cycle: the register reloads and `out_valid` stays 1. This sustains back-to-back words.
- Hold: while `out_valid && !out_ready`, `out_data`, `out_len` and `out_err` are stable and `in_ready` is 0. No nibble is lost or reordered.
- States, implicit via `idx` and `out_valid`:
  - EMPTY: `idx==0`, `!out_valid`.
  - FILL: `idx>0`.
  - HELD: `out_valid`.
- `in_last` on the first nibble of a word produces `out_len` = 1.
- `in_q` is packed unmodified. 4'hf is legal data; only `in_sel` determines error.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_len`=0, `out_err`=0, `err_count`=0.
  - Internal `acc`=0, `idx`=0, `werr`=0.
  - `in_ready`=1 in the first cycle after reset.
- Reset mid-word discards the partial word and any held word. The next accept is nibble 0.
- Latency: the closing accept at edge N gives `out_valid`=1 from edge N onward, i.e. visible in cycle N+1.
- Throughput: one nibble per cycle, with no bubbles between words while `out_ready` is 1.
- `in_ready` depends combinationally on `out_ready`. There are no other combinational input-to-output paths.
- Inputs are ignored when `in_valid`=0, including `in_last` and `in_sel`.

## Structure
- Shared package `mux_pkg`:
  - `SEL_B`=0, `SEL_E`=1, `SEL_A`=2, `SEL_D`=3.
  - `SEL_MAX`=3.
  - `Q_DEFAULT`=4'hf.
  - typedef `nibble_t` (logic [3:0]).
- Optional sub-module `nibble_accumulator`, containing `acc`, `idx`, `werr` and the close detect. The output register and handshake stay in the top module.

## Test plan
- Reset: assert `reset` 2 cycles -> `out_valid`=0, `in_ready`=1, `err_count`=0, `out_data`=16'h0000.
- Back-to-back packing: `q`=1,2,3,4 with `sel`=0,1,2,3 on consecutive cycles, `out_ready`=1 -> `out_data`=16'h4321, `out_len`=4, `out_err`=0, `out_valid` high the cycle after the 4th accept. Immediately follow with `q`=5..8 -> 16'h8765 with no bubble.
- Backpressure: hold `out_ready`=0 after the first word -> `in_ready`=0 and `out_data` stable for 5 cycles. Release -> the second word completes unchanged and in order.
- Early close: `q`=a,b with `in_last` on `b` -> `out_data`=16'h00ba, `out_len`=2. Then `in_last` on a single nibble `q`=7 -> `out_data`=16'h0007, `out_len`=1.
- Error flag and saturation:
  - `q`=f with `sel`=5 in a word -> `out_err`=1 and `err_count` +1.
  - `q`=f with `sel`=0 -> no error.
  - 300 out-of-range accepts -> `err_count`=255.
- Reset mid-word: accept 2 nibbles, then reset -> no word emitted. Next 4 nibbles 9,a,b,c -> `out_data`=16'hcba9.
